// File: rtl/clk_div_sched_pkg.sv
// Shared definitions for clk_div_sched: state encoding and the divisor clamp.
// The clamp is used only when CLK_DIV_SCHED_CFG_EN is defined.
package clk_div_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A divisor below 2 cannot form a count cycle, so it is raised to 2.
    function automatic int unsigned eff_div(input int unsigned d);
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Command and status bundle between the command source (master) and clk_div_sched (slave).
// CLK_DIV_SCHED_CFG_EN adds the run-time divisor inputs cfg_div_a/cfg_div_b.
interface clk_div_sched_if #(
    parameter int CNT_A_W = 6,
    parameter int CNT_B_W = 4,
    parameter int RUN_W   = 8
);
    logic               cmd_start;
    logic               cmd_stop;
    logic               cmd_pause;
    logic [RUN_W-1:0]   run_len;
`ifdef CLK_DIV_SCHED_CFG_EN
    logic [CNT_A_W-1:0] cfg_div_a;
    logic [CNT_B_W-1:0] cfg_div_b;
`endif
    logic [CNT_A_W-1:0] count_a;
    logic [CNT_B_W-1:0] count_b;
    logic               tick_a;
    logic               tick_b;
    logic               div_a_lvl;
    logic               div_b_lvl;
    logic               busy;
    logic               done;
    logic [1:0]         state;

    modport master (
`ifdef CLK_DIV_SCHED_CFG_EN
        output cfg_div_a, cfg_div_b,
`endif
        output cmd_start, cmd_stop, cmd_pause, run_len,
        input  count_a, count_b, tick_a, tick_b, div_a_lvl, div_b_lvl, busy, done, state
    );

    modport slave (
`ifdef CLK_DIV_SCHED_CFG_EN
        input  cfg_div_a, cfg_div_b,
`endif
        input  cmd_start, cmd_stop, cmd_pause, run_len,
        output count_a, count_b, tick_a, tick_b, div_a_lvl, div_b_lvl, busy, done, state
    );

endinterface

// File: rtl/clk_div_sched_div_stage.sv
// One divider stage: counts 0..terminal while enabled, strobes wrap and toggles level on wrap.
// wrap reports an enabled terminal count even when clr empties the stage on the same edge.
module div_stage #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         level
);

    logic at_term;

    assign at_term = (count == terminal);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            level <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wrap <= en && at_term;
            if (clr) begin
                count <= '0;
                level <= 1'b0;
            end else if (en) begin
                if (at_term) begin
                    count <= '0;
                    level <= ~level;
                end else begin
                    count <= count + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Run controller for the cascaded A/B divider: command FSM, run-length counter, clock-enable ticks.
// Defining CLK_DIV_SCHED_CFG_EN replaces DIV_A/DIV_B with divisors latched from the cfg ports on start.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int DIV_A   = 50,
    parameter int DIV_B   = 10,
    parameter int CNT_A_W = 6,
    parameter int CNT_B_W = 4,
    parameter int RUN_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_sched_if.slave bus
);

    logic [1:0]         state_q, state_d;
    logic               clr, en_a, en_b, latch, done_d;
    logic               hit_a, hit_b, final_wrap;
    logic               busy_q, done_q;
    logic [RUN_W-1:0]   run_len_q, periods;
    logic [CNT_A_W-1:0] term_a, count_a;
    logic [CNT_B_W-1:0] term_b, count_b;
    logic               tick_a, tick_b, lvl_a, lvl_b;

`ifdef CLK_DIV_SCHED_CFG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            term_a <= CNT_A_W'(DIV_A - 1);
            term_b <= CNT_B_W'(DIV_B - 1);
        end else if (latch) begin
            term_a <= CNT_A_W'(eff_div(32'(bus.cfg_div_a)) - 1);
            term_b <= CNT_B_W'(eff_div(32'(bus.cfg_div_b)) - 1);
        end
    end
`else
    assign term_a = CNT_A_W'(DIV_A - 1);
    assign term_b = CNT_B_W'(DIV_B - 1);
`endif

    assign hit_a      = (count_a == term_a);
    assign hit_b      = hit_a && (count_b == term_b);
    assign en_b       = en_a && hit_a;
    // periods counts completed B cycles, so this wrap completes the run when one is still owed.
    assign final_wrap = (run_len_q != '0) && hit_b && (periods == run_len_q - RUN_W'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        clr     = 1'b0;
        en_a    = 1'b0;
        latch   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                    latch   = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.cmd_stop) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else if (bus.cmd_start) begin
                    clr     = 1'b1;
                    latch   = 1'b1;
                end else if (bus.cmd_pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    en_a = 1'b1;
                    if (final_wrap) begin
                        state_d = ST_DONE;
                        clr     = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.cmd_stop) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else if (bus.cmd_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!bus.cmd_stop && bus.cmd_start) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                    latch   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            run_len_q <= '0;
            periods   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            done_q  <= done_d;
            if (latch)
                run_len_q <= bus.run_len;
            // Saturating, so a free run never wraps back into a false completion.
            if (clr)
                periods <= '0;
            else if (en_a && hit_b && (periods != '1))
                periods <= periods + RUN_W'(1);
        end
    end

    div_stage #(.W(CNT_A_W)) u_stage_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en_a),
        .clr      (clr),
        .terminal (term_a),
        .count    (count_a),
        .wrap     (tick_a),
        .level    (lvl_a)
    );

    div_stage #(.W(CNT_B_W)) u_stage_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en_b),
        .clr      (clr),
        .terminal (term_b),
        .count    (count_b),
        .wrap     (tick_b),
        .level    (lvl_b)
    );

    assign bus.count_a   = count_a;
    assign bus.count_b   = count_b;
    assign bus.tick_a    = tick_a;
    assign bus.tick_b    = tick_b;
    assign bus.div_a_lvl = lvl_a;
    assign bus.div_b_lvl = lvl_b;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: a run-time model (elapsed advancing cycles t) predicts each edge.
// With CLK_DIV_SCHED_CFG_EN defined the bench also drives and models the cfg divisors.
module tb_clk_div_sched;

    localparam int DIV_A   = 50;
    localparam int DIV_B   = 10;
    localparam int CNT_A_W = 6;
    localparam int CNT_B_W = 4;
    localparam int RUN_W   = 8;

    typedef struct {
        int ca, cb, ta, tk, la, lb, busy, done, st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    clk_div_sched_if #(.CNT_A_W(CNT_A_W), .CNT_B_W(CNT_B_W), .RUN_W(RUN_W)) bus ();

    clk_div_sched #(
        .DIV_A(DIV_A), .DIV_B(DIV_B), .CNT_A_W(CNT_A_W), .CNT_B_W(CNT_B_W), .RUN_W(RUN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     mon_cyc = 0;
    int     tickb_seen = 0;

    // Reference model: state 0..3 and t = clk edges on which the current run advanced.
    int     m_st, rl, da, db, m_ta, m_tb, m_dn;
    longint t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, mon_cyc, got, want);
        end
    endtask

    function automatic void m_reset();
        m_st = 0; t = 0; rl = 0; da = DIV_A; db = DIV_B;
        m_ta = 0; m_tb = 0; m_dn = 0;
    endfunction

    function automatic void m_begin();
        m_st = 1; t = 0; rl = int'(bus.run_len);
`ifdef CLK_DIV_SCHED_CFG_EN
        da = (bus.cfg_div_a < 2) ? 2 : int'(bus.cfg_div_a);
        db = (bus.cfg_div_b < 2) ? 2 : int'(bus.cfg_div_b);
`else
        da = DIV_A; db = DIV_B;
`endif
    endfunction

    function automatic void m_step(input bit s, input bit p, input bit stp);
        m_ta = 0; m_tb = 0; m_dn = 0;
        case (m_st)
            0: if (s) m_begin();
            1: begin
                if (stp) begin m_st = 0; t = 0; end
                else if (s) m_begin();
                else if (p) m_st = 2;
                else begin
                    t++;
                    m_ta = int'(t % da == 0);
                    m_tb = int'(t % (da * db) == 0);
                    if (rl != 0 && t == longint'(rl) * da * db) begin
                        m_st = 3; m_dn = 1; t = 0;
                    end
                end
            end
            2: begin
                if (stp) begin m_st = 0; t = 0; end
                else if (s) m_st = 1;
            end
            default: begin
                if (!stp && s) m_begin();
                else m_st = 0;
            end
        endcase
    endfunction

    function automatic exp_t m_view();
        exp_t e;
        e.ca   = int'(t % da);
        e.cb   = int'((t / da) % db);
        e.la   = int'((t / da) % 2);
        e.lb   = int'((t / (da * db)) % 2);
        e.ta   = m_ta;
        e.tk   = m_tb;
        e.done = m_dn;
        e.busy = int'(m_st == 1 || m_st == 2);
        e.st   = m_st;
        return e;
    endfunction

    task automatic cycle(input bit r, input bit s, input bit p, input bit stp);
        @(negedge clk);
        rst = r;
        bus.cmd_start = s;
        bus.cmd_pause = p;
        bus.cmd_stop  = stp;
        if (!r) m_reset();
        else m_step(s, p, stp);
        sb_q.push_back(m_view());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Advances until the model predicts the given run position; a missed target is a failure.
    task automatic run_until(input string name, input int want_ca, input int want_cb, input int limit);
        bit hit = 0;
        for (int i = 0; i < limit; i++) begin
            if (m_st == 1 && t % da == want_ca && (want_cb < 0 || (t / da) % db == want_cb)) begin
                hit = 1;
                break;
            end
            idle(1);
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic set_cfg(input int a, input int b);
`ifdef CLK_DIV_SCHED_CFG_EN
        bus.cfg_div_a = CNT_A_W'(a);
        bus.cfg_div_b = CNT_B_W'(b);
`else
        if (a != DIV_A || b != DIV_B) $display("note: cfg ignored in default build");
`endif
    endtask

    // Monitor: pops one prediction per clock edge and compares every output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_cyc++;
                mon_e = sb_q.pop_front();
                check("count_a",   32'(bus.count_a),   32'(mon_e.ca));
                check("count_b",   32'(bus.count_b),   32'(mon_e.cb));
                check("tick_a",    32'(bus.tick_a),    32'(mon_e.ta));
                check("tick_b",    32'(bus.tick_b),    32'(mon_e.tk));
                check("div_a_lvl", 32'(bus.div_a_lvl), 32'(mon_e.la));
                check("div_b_lvl", 32'(bus.div_b_lvl), 32'(mon_e.lb));
                check("busy",      32'(bus.busy),      32'(mon_e.busy));
                check("done",      32'(bus.done),      32'(mon_e.done));
                check("state",     32'(bus.state),     32'(mon_e.st));
                if (bus.tick_b === 1'b1) tickb_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        bus.cmd_pause = 1'b0;
        bus.run_len   = '0;
        set_cfg(DIV_A, DIV_B);
        m_reset();

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Run of two B periods: done lands 1000 edges after start, then IDLE.
        bus.run_len = 8'd2;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1010);

        // Pause at count_a=17 for 30 cycles, then resume.
        bus.run_len = 8'd0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_until("reach count_a 17", 17, -1, 200);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(29);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(60);

        // Stop and start together: stop wins.
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        idle(5);

        // Asynchronous reset mid-run at count_b=6.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_until("reach count_b 6", 20, 6, 1000);
        @(negedge clk);
        #3;
        rst = 1'b0;
        bus.cmd_start = 1'b0;
        m_reset();
        sb_q.push_back(m_view());
        #1;
        check("async reset outputs", 32'({bus.count_a, bus.count_b, bus.tick_a, bus.tick_b, bus.div_a_lvl,
              bus.div_b_lvl, bus.busy, bus.done, bus.state}), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);

        // Free run for 12000 edges: 24 tick_b pulses, no done.
        bus.run_len = 8'd0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        tickb_seen = 0;
        idle(12000);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("free-run tick_b pulses", 32'(tickb_seen), 32'd24);

        // Pause on the final wrap wins over done; resume then completes; start in DONE begins a new run.
        bus.run_len = 8'd1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_until("reach final wrap (pause)", 49, 9, 600);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_until("reach final wrap (stop)", 49, 9, 600);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

`ifdef CLK_DIV_SCHED_CFG_EN
        // Sub-minimum cfg divisors clamp to 2: tick_a every 2 edges, tick_b every 6.
        set_cfg(1, 3);
        bus.run_len = 8'd0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        set_cfg(DIV_A, DIV_B);
`endif

        // Randomized command mix with short runs.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                bus.run_len = RUN_W'($urandom_range(0, 3));
`ifdef CLK_DIV_SCHED_CFG_EN
                set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
`endif
            end
            cycle(1'b1, r < 5, r >= 8 && r < 15, r >= 5 && r < 8);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
